// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants, bank-count helper and FSM encoding for dpram_banked
package dpram_pkg;

  // Capacity of one BSRAM block in bits.
  localparam int BANK_BITS = 16384;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Number of BSRAM-sized banks needed to hold 2^addr_width words of data_width bits.
  function automatic int nbanks(input int data_width, input int addr_width);
    int total;
    int n;
    total = (1 << addr_width) * data_width;
    n     = (total + BANK_BITS - 1) / BANK_BITS;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/dpram_bank.sv
// rtl/dpram_bank.sv - one BSRAM-sized true dual-port bank with byte-lane write enables
// Ports: clk, resetn (async, active-low, clears read registers)
//        addr_x / din_x / wl_x (per-lane write enable) / re_x (read) / q_x (registered read data)
// q_x updates only when re_x is high and holds otherwise.  A read that hits a location
// written in the same cycle returns the old contents; the caller forwards new data.
module dpram_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     addr_a,
  input  logic [DATA_WIDTH-1:0]     din_a,
  input  logic [DATA_WIDTH/8-1:0]   wl_a,
  input  logic                      re_a,
  output logic [DATA_WIDTH-1:0]     q_a,
  input  logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     din_b,
  input  logic [DATA_WIDTH/8-1:0]   wl_b,
  input  logic                      re_b,
  output logic [DATA_WIDTH-1:0]     q_b
);

  localparam int NL = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_q_a;
  logic [DATA_WIDTH-1:0] r_q_b;

  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (wl_a[l]) r_mem[addr_a][l*8 +: 8] <= din_a[l*8 +: 8];
      if (wl_b[l]) r_mem[addr_b][l*8 +: 8] <= din_b[l*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      if (re_a) r_q_a <= r_mem[addr_a];
      if (re_b) r_q_b <= r_mem[addr_b];
    end
  end

  assign q_a = r_q_a;
  assign q_b = r_q_b;

endmodule

// File: rtl/dpram_banked.sv
// rtl/dpram_banked.sv - banked true dual-port RAM with byte enables, collision forwarding and post-reset clear
// Ports: clk, resetn (async, active-low); ready (array usable)
//        addr_x / din_x / be_x / we_x / re_x per port; dout_x / valid_x registered read result
module dpram_banked
  import dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      ready,
  input  logic [ADDR_WIDTH-1:0]     addr_a,
  input  logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     din_a,
  input  logic [DATA_WIDTH-1:0]     din_b,
  input  logic [DATA_WIDTH/8-1:0]   be_a,
  input  logic [DATA_WIDTH/8-1:0]   be_b,
  input  logic                      we_a,
  input  logic                      we_b,
  input  logic                      re_a,
  input  logic                      re_b,
  output logic [DATA_WIDTH-1:0]     dout_a,
  output logic [DATA_WIDTH-1:0]     dout_b,
  output logic                      valid_a,
  output logic                      valid_b
);

  localparam int     NL       = DATA_WIDTH / 8;
  localparam int     NB       = nbanks(DATA_WIDTH, ADDR_WIDTH);
  localparam int     SEL_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int     OFF_W    = (NB > 1) ? ADDR_WIDTH - $clog2(NB) : ADDR_WIDTH;
  localparam int     NSLOT    = 2 ** SEL_W;
  localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_RESET;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_addr == '1) w_state_nxt = ST_RUN;
  end

  logic w_run;
  assign w_run = (r_state == ST_RUN);
  assign ready = w_run;

  // Port B is borrowed by the clear sweep; user requests are dropped until RUN.
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [DATA_WIDTH-1:0] w_din_b;
  logic [NL-1:0]         w_wl_a;
  logic [NL-1:0]         w_wl_b;
  logic                  w_rd_a;
  logic                  w_rd_b;
  logic                  w_same;
  logic [NL-1:0]         w_fl_a;
  logic [NL-1:0]         w_fl_b;

  assign w_addr_b = w_run ? addr_b : r_clr_addr;
  assign w_din_b  = w_run ? din_b : CLEAR_VALUE;
  assign w_same   = (addr_a == addr_b);
  assign w_rd_a   = w_run & re_a & ~we_a;
  assign w_rd_b   = w_run & re_b & ~we_b;
  assign w_wl_a   = (w_run & we_a) ? be_a : '0;

  // Port A owns any lane both ports write to the same word.
  always_comb begin
    w_wl_b = '0;
    if (!w_run)    w_wl_b = '1;
    else if (we_b) w_wl_b = be_b & ~(w_same ? w_wl_a : '0);
  end

  // Lanes the other port writes this cycle override the bank's old data at the output.
  assign w_fl_a = (w_rd_a && w_same) ? w_wl_b : '0;
  assign w_fl_b = (w_rd_b && w_same) ? w_wl_a : '0;

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;

  if (NB > 1) begin : g_sel
    assign w_sel_a = addr_a[ADDR_WIDTH-1 -: SEL_W];
    assign w_sel_b = w_addr_b[ADDR_WIDTH-1 -: SEL_W];
  end else begin : g_nosel
    assign w_sel_a = '0;
    assign w_sel_b = '0;
  end

  logic [DATA_WIDTH-1:0] w_q_a [NSLOT];
  logic [DATA_WIDTH-1:0] w_q_b [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_bank
    if (g < NB) begin : g_used
      logic w_hit_a;
      logic w_hit_b;
      assign w_hit_a = (w_sel_a == SEL_W'(g));
      assign w_hit_b = (w_sel_b == SEL_W'(g));
      dpram_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(OFF_W)
      ) u_bank (
        .clk    (clk),
        .resetn (resetn),
        .addr_a (addr_a[OFF_W-1:0]),
        .din_a  (din_a),
        .wl_a   (w_hit_a ? w_wl_a : '0),
        .re_a   (w_hit_a & w_rd_a),
        .q_a    (w_q_a[g]),
        .addr_b (w_addr_b[OFF_W-1:0]),
        .din_b  (w_din_b),
        .wl_b   (w_hit_b ? w_wl_b : '0),
        .re_b   (w_hit_b & w_rd_b),
        .q_b    (w_q_b[g])
      );
    end else begin : g_pad
      assign w_q_a[g] = '0;
      assign w_q_b[g] = '0;
    end
  end

  // Bank select and forwarding info travel with the read; they only change on a read,
  // so the merged word below holds between reads.
  logic                  r_v1_a, r_v1_b;
  logic [SEL_W-1:0]      r_sel_a, r_sel_b;
  logic [NL-1:0]         r_fl_a, r_fl_b;
  logic [DATA_WIDTH-1:0] r_fd_a, r_fd_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1_a  <= 1'b0;
      r_v1_b  <= 1'b0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_fl_a  <= '0;
      r_fl_b  <= '0;
      r_fd_a  <= '0;
      r_fd_b  <= '0;
    end else begin
      r_v1_a <= w_rd_a;
      r_v1_b <= w_rd_b;
      if (w_rd_a) begin
        r_sel_a <= w_sel_a;
        r_fl_a  <= w_fl_a;
        r_fd_a  <= din_b;
      end
      if (w_rd_b) begin
        r_sel_b <= w_sel_b;
        r_fl_b  <= w_fl_b;
        r_fd_b  <= din_a;
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_m_a;
  logic [DATA_WIDTH-1:0] w_m_b;

  always_comb begin
    w_m_a = w_q_a[r_sel_a];
    w_m_b = w_q_b[r_sel_b];
    for (int l = 0; l < NL; l++) begin
      if (r_fl_a[l]) w_m_a[l*8 +: 8] = r_fd_a[l*8 +: 8];
      if (r_fl_b[l]) w_m_b[l*8 +: 8] = r_fd_b[l*8 +: 8];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
    logic                  r_v2_a, r_v2_b;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_dout_a <= '0;
        r_dout_b <= '0;
        r_v2_a   <= 1'b0;
        r_v2_b   <= 1'b0;
      end else begin
        r_v2_a <= r_v1_a;
        r_v2_b <= r_v1_b;
        if (r_v1_a) r_dout_a <= w_m_a;
        if (r_v1_b) r_dout_b <= w_m_b;
      end
    end

    assign dout_a  = r_dout_a;
    assign dout_b  = r_dout_b;
    assign valid_a = r_v2_a;
    assign valid_b = r_v2_b;
  end else begin : g_noreg
    assign dout_a  = w_m_a;
    assign dout_b  = w_m_b;
    assign valid_a = r_v1_a;
    assign valid_b = r_v1_b;
  end

endmodule
